// File: rtl/excep_pkg.sv
// Shared types and constants for the exception sequencer: states, cause codes,
// grant/ESR bit positions and handler vector offsets.
package excep_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StDrain,
    StSave,
    StRedirect
  } state_e;

  typedef enum logic [3:0] {
    CauseNone  = 4'd0,
    CauseIsi   = 4'd1,
    CauseProg  = 4'd2,
    CauseSc    = 4'd3,
    CauseAlign = 4'd4,
    CauseDsi   = 4'd5,
    CauseExt   = 4'd6
  } cause_e;

  // Grant indices double as ESR bit positions.
  localparam int unsigned NumSrc      = 6;
  localparam int unsigned EsrIsiBit   = 0;
  localparam int unsigned EsrProgBit  = 1;
  localparam int unsigned EsrScBit    = 2;
  localparam int unsigned EsrAlignBit = 3;
  localparam int unsigned EsrDsiBit   = 4;
  localparam int unsigned EsrExtBit   = 5;

  localparam logic [31:0] VecDsi   = 32'h0000_0300;
  localparam logic [31:0] VecIsi   = 32'h0000_0400;
  localparam logic [31:0] VecExt   = 32'h0000_0500;
  localparam logic [31:0] VecAlign = 32'h0000_0600;
  localparam logic [31:0] VecProg  = 32'h0000_0700;
  localparam logic [31:0] VecSc    = 32'h0000_0C00;

  function automatic logic [31:0] vec_offset(cause_e cause);
    logic [31:0] off;
    off = 32'h0;
    case (cause)
      CauseIsi:   off = VecIsi;
      CauseProg:  off = VecProg;
      CauseSc:    off = VecSc;
      CauseAlign: off = VecAlign;
      CauseDsi:   off = VecDsi;
      CauseExt:   off = VecExt;
      default:    off = 32'h0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/excep_prio_enc.sv
// Fixed-priority exception arbiter: ISI > PROG > SC > ALIGN > DSI > EXT.
// Grants only while the sequencer is idle; EXT also needs msr_ee.
module excep_prio_enc
  import excep_pkg::*;
(
  input  logic              idle_i,
  input  logic [4:0]        sync_req_i,  // {dsi, align, sc, prog, isi}
  input  logic              ext_int_i,
  input  logic              msr_ee_i,
  output cause_e            cause_o,
  output logic [NumSrc-1:0] grant_o
);

  always_comb begin
    cause_o = CauseNone;
    grant_o = '0;
    if (idle_i) begin
      if (sync_req_i[EsrIsiBit]) begin
        cause_o = CauseIsi;
        grant_o[EsrIsiBit] = 1'b1;
      end else if (sync_req_i[EsrProgBit]) begin
        cause_o = CauseProg;
        grant_o[EsrProgBit] = 1'b1;
      end else if (sync_req_i[EsrScBit]) begin
        cause_o = CauseSc;
        grant_o[EsrScBit] = 1'b1;
      end else if (sync_req_i[EsrAlignBit]) begin
        cause_o = CauseAlign;
        grant_o[EsrAlignBit] = 1'b1;
      end else if (sync_req_i[EsrDsiBit]) begin
        cause_o = CauseDsi;
        grant_o[EsrDsiBit] = 1'b1;
      end else if (ext_int_i && msr_ee_i) begin
        cause_o = CauseExt;
        grant_o[EsrExtBit] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/excep_sequencer.sv
// Exception entry sequencer: accepts one request while idle, flushes, waits for
// the pipeline to drain, writes SRR0/ESR/DEAR, then redirects fetch to the handler.
module excep_sequencer
  import excep_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_isi_i,
  input  logic        req_prog_i,
  input  logic        req_sc_i,
  input  logic        req_align_i,
  input  logic        req_dsi_i,
  input  logic [2:0]  prog_cause_i,
  input  logic [31:0] req_pc_i,
  input  logic [31:0] req_addr_i,
  input  logic        ext_int_i,
  input  logic        msr_ee_i,
  input  logic        pipe_idle_i,
  output logic        flush_o,
  output logic        busy_o,
  output logic        srr_we_o,
  output logic [31:0] srr0_o,
  output logic [7:0]  esr_o,
  output logic        dear_we_o,
  output logic [31:0] dear_o,
  output logic        msr_ee_clr_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic [3:0]  excep_code_o
);

  state_e            state_q, state_d;
  cause_e            cause_q, win_cause;
  logic [NumSrc-1:0] grant;
  logic [31:0]       srr0_q, srr0_d, dear_q, redirect_pc_q, redirect_pc_d;
  logic [7:0]        esr_q, esr_d;

  excep_prio_enc u_prio_enc (
    .idle_i     (state_q == StIdle),
    .sync_req_i ({req_dsi_i, req_align_i, req_sc_i, req_prog_i, req_isi_i}),
    .ext_int_i  (ext_int_i),
    .msr_ee_i   (msr_ee_i),
    .cause_o    (win_cause),
    .grant_o    (grant)
  );

  always_comb begin
    esr_d = {2'b00, grant};
    if (grant[EsrProgBit]) begin
      esr_d[7:5] = prog_cause_i;
    end
    // System call returns past the sc instruction.
    srr0_d        = grant[EsrScBit] ? (req_pc_i + 32'd4) : req_pc_i;
    redirect_pc_d = VEC_BASE + vec_offset(win_cause);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cause_q       <= CauseNone;
      srr0_q        <= '0;
      esr_q         <= '0;
      dear_q        <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (win_cause != CauseNone) begin
        cause_q       <= win_cause;
        srr0_q        <= srr0_d;
        esr_q         <= esr_d;
        dear_q        <= req_addr_i;
        redirect_pc_q <= redirect_pc_d;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    flush_o          = 1'b0;
    busy_o           = 1'b1;
    srr_we_o         = 1'b0;
    msr_ee_clr_o     = 1'b0;
    dear_we_o        = 1'b0;
    redirect_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_o = 1'b0;
        if (win_cause != CauseNone) state_d = StCapture;
      end
      StCapture: begin
        flush_o = 1'b1;
        state_d = StDrain;
      end
      StDrain: begin
        if (pipe_idle_i) state_d = StSave;
      end
      StSave: begin
        srr_we_o     = 1'b1;
        msr_ee_clr_o = 1'b1;
        dear_we_o    = (cause_q == CauseAlign) || (cause_q == CauseDsi);
        state_d      = StRedirect;
      end
      StRedirect: begin
        redirect_valid_o = 1'b1;
        state_d          = StIdle;
      end
      default: begin
        busy_o  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  assign srr0_o        = srr0_q;
  assign esr_o         = esr_q;
  assign dear_o        = dear_q;
  assign redirect_pc_o = redirect_pc_q;
  assign excep_code_o  = busy_o ? cause_q : CauseNone;

endmodule

// File: tb/tb_excep_sequencer.sv
// Randomized self-checking bench for excep_sequencer against a per-transaction
// timeline model derived from the priority, vector and timing rules.
module tb_excep_sequencer;
  import excep_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_isi, req_prog, req_sc, req_align, req_dsi;
  logic [2:0]  prog_cause;
  logic [31:0] req_pc, req_addr;
  logic        ext_int, msr_ee, pipe_idle;
  logic        flush, busy, srr_we, dear_we, msr_ee_clr, redirect_valid;
  logic [31:0] srr0, dear, redirect_pc;
  logic [7:0]  esr;
  logic [3:0]  excep_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  excep_sequencer #(.VEC_BASE(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_isi_i        (req_isi),
    .req_prog_i       (req_prog),
    .req_sc_i         (req_sc),
    .req_align_i      (req_align),
    .req_dsi_i        (req_dsi),
    .prog_cause_i     (prog_cause),
    .req_pc_i         (req_pc),
    .req_addr_i       (req_addr),
    .ext_int_i        (ext_int),
    .msr_ee_i         (msr_ee),
    .pipe_idle_i      (pipe_idle),
    .flush_o          (flush),
    .busy_o           (busy),
    .srr_we_o         (srr_we),
    .srr0_o           (srr0),
    .esr_o            (esr),
    .dear_we_o        (dear_we),
    .dear_o           (dear),
    .msr_ee_clr_o     (msr_ee_clr),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .excep_code_o     (excep_code)
  );

  // {flush, busy, srr_we, msr_ee_clr, dear_we, redirect_valid, excep_code}
  logic [9:0] status;
  assign status = {flush, busy, srr_we, msr_ee_clr, dear_we, redirect_valid, excep_code};

  // Priority order ISI, PROG, SC, ALIGN, DSI, EXT.
  logic [31:0] vec_tbl [6] = '{32'h400, 32'h700, 32'hC00, 32'h600, 32'h300, 32'h500};
  logic [3:0]  code_tbl[6] = '{CauseIsi, CauseProg, CauseSc, CauseAlign, CauseDsi, CauseExt};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] sync, input logic ext, input logic ee,
                       input logic [31:0] pc, input logic [31:0] addr, input logic [2:0] pcause);
    {req_dsi, req_align, req_sc, req_prog, req_isi} = sync;
    ext_int    = ext;
    msr_ee     = ee;
    req_pc     = pc;
    req_addr   = addr;
    prog_cause = pcause;
  endtask

  // sync = {dsi, align, sc, prog, isi}; w = cycles pipe_idle stays low in DRAIN.
  task automatic run_seq(input string tag, input logic [4:0] sync, input logic ext,
                         input logic ee, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [2:0] pcause, input int w, input bit noise);
    int idx;
    logic [7:0]  e_esr;
    logic [31:0] e_srr0;
    logic [9:0]  e_st;
    bit          is_data;
    idx = -1;
    for (int i = 0; i < 5; i++) if (sync[i] && idx < 0) idx = i;
    if (idx < 0 && ext && ee) idx = 5;

    @(posedge clk); #1;
    drive(sync, ext, ee, pc, addr, pcause);
    pipe_idle = (w == 0);
    @(negedge clk);
    check_eq({tag, "_pre"}, status, 10'h0);

    if (idx < 0) begin
      @(posedge clk); #1;
      drive(5'b0, 1'b0, ee, pc, addr, 3'b0);
      @(negedge clk);
      check_eq({tag, "_noacc"}, status, 10'h0);
      return;
    end

    e_esr   = 8'(1 << idx);
    if (idx == 1) e_esr = {pcause, 5'b00010};
    e_srr0  = (idx == 2) ? pc + 32'd4 : pc;
    is_data = (idx == 3) || (idx == 4);

    for (int k = 1; k <= 5 + w; k++) begin
      @(posedge clk); #1;
      if (noise && k <= 4 + w)
        drive(5'($urandom_range(0, 31)), 1'($urandom), ee, $urandom, $urandom, 3'b010);
      else
        drive(5'b0, 1'b0, ee, 32'h0, 32'h0, 3'b0);
      pipe_idle = (k >= 2 + w) || (w == 0);
      @(negedge clk);
      e_st = '0;
      if (k <= 4 + w) begin
        e_st[8]   = 1'b1;
        e_st[3:0] = code_tbl[idx];
      end
      e_st[9] = (k == 1);
      e_st[7] = (k == 3 + w);
      e_st[6] = (k == 3 + w);
      e_st[5] = (k == 3 + w) && is_data;
      e_st[4] = (k == 4 + w);
      check_eq($sformatf("%s_st_k%0d", tag, k), status, e_st);
      if (k == 3 + w) begin
        check_eq({tag, "_srr0"}, srr0, e_srr0);
        check_eq({tag, "_esr"}, esr, e_esr);
        if (is_data) check_eq({tag, "_dear"}, dear, addr);
      end
      if (k == 4 + w) check_eq({tag, "_vec"}, redirect_pc, vec_tbl[idx]);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(5'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    pipe_idle = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_status", status, 10'h0);
    check_eq("reset_srr0", srr0, 32'h0);
    check_eq("reset_esr", esr, 8'h0);
    check_eq("reset_dear", dear, 32'h0);
    check_eq("reset_vec", redirect_pc, 32'h0);

    run_seq("sc", 5'b00100, 1'b0, 1'b0, 32'h100, 32'h0, 3'b0, 0, 1'b0);
    run_seq("isi_dsi", 5'b10001, 1'b0, 1'b0, 32'h2000, 32'h3000, 3'b0, 0, 1'b0);
    run_seq("dsi_wait", 5'b10000, 1'b0, 1'b0, 32'h40, 32'hDEAD_BEE0, 3'b0, 5, 1'b0);
    run_seq("prog", 5'b00010, 1'b0, 1'b0, 32'h80, 32'h0, 3'b100, 1, 1'b0);
    run_seq("align", 5'b01000, 1'b0, 1'b0, 32'h1234, 32'h5671, 3'b0, 2, 1'b1);

    // External interrupt masked, then enabled.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(5'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b0);
      @(negedge clk);
      check_eq($sformatf("ext_masked_%0d", i), status, 10'h0);
    end
    run_seq("ext", 5'b0, 1'b1, 1'b1, 32'h900, 32'h0, 3'b0, 0, 1'b0);
    msr_ee = 1'b0;

    // Reset while in DRAIN.
    @(posedge clk); #1;
    drive(5'b00100, 1'b0, 1'b0, 32'h700, 32'h0, 3'b0);
    pipe_idle = 1'b0;
    @(posedge clk); #1;
    drive(5'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_in_drain", status, {2'b01, 4'b0, 4'(CauseSc)});
    @(posedge clk); #1;
    rst = 1'b0;
    pipe_idle = 1'b1;
    @(negedge clk);
    check_eq("rst_after_status", status, 10'h0);
    check_eq("rst_after_srr0", srr0, 32'h0);
    check_eq("rst_after_vec", redirect_pc, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("rst_quiet_%0d", i), status, 10'h0);
    end
    run_seq("sc_wrap", 5'b00100, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 3'b0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [4:0] sync;
      for (int i = 0; i < 5; i++) sync[i] = ($urandom_range(0, 3) == 0);
      run_seq($sformatf("rnd%0d", t), sync, 1'($urandom), 1'($urandom), $urandom, $urandom,
              3'(1 << $urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/excep_sequencer.md
EXCEP_SEQUENCER -- requirements
Module: excep_sequencer

Interface
REQ-001 Parameter VEC_BASE, 32'h0000_0000: base address added to every vector offset.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_isi, req_prog, req_sc, req_align, req_dsi  input  1 each  exception requests from the commit stage, each sampled high for one cycle.
REQ-005 prog_cause  input  3  program sub-cause, one-hot {trap, illegal, privileged}; valid with req_prog.
REQ-006 req_pc  input  32  PC of the committing instruction; valid with any request.
REQ-007 req_addr  input  32  faulting data address; valid with req_align/req_dsi.
REQ-008 ext_int  input  1  external interrupt level.
REQ-009 msr_ee  input  1  external-interrupt enable.
REQ-010 pipe_idle  input  1  pipeline drained after flush.
REQ-011 flush  output  1  flush all stages.
REQ-012 busy  output  1  sequence in progress; fetch stalled.
REQ-013 srr_we, srr0, esr  output  1/32/8  write save/restore PC and cause register.
REQ-014 dear_we, dear  output  1/32  write data-exception address register.
REQ-015 msr_ee_clr  output  1  clear MSR[EE].
REQ-016 redirect_valid, redirect_pc  output  1/32  steer fetch to the handler.
REQ-017 excep_code  output  4  latched cause code (0 = none).

Function
REQ-018 States IDLE, CAPTURE, DRAIN, SAVE, REDIRECT; IDLE->CAPTURE on any accepted request; CAPTURE->DRAIN; DRAIN->SAVE when pipe_idle; SAVE->REDIRECT; REDIRECT->IDLE.
REQ-019 Acceptance only in IDLE; requests in other states are ignored, never queued.
REQ-020 Fixed priority among simultaneous requests: ISI > PROG > SC > ALIGN > DSI > EXT; only the winner is latched.
REQ-021 ext_int accepted only when msr_ee=1, state IDLE, and no synchronous request is present.
REQ-022 Vector offsets: DSI 0x300, ISI 0x400, EXT 0x500, ALIGN 0x600, PROG 0x700, SC 0xC00; redirect_pc = VEC_BASE + offset, modulo 2^32.
REQ-023 srr0 = req_pc + 4 (modulo 2^32, wraps 0xFFFF_FFFC->0) for SC; req_pc for all others.
REQ-024 esr: bit0 ISI, bit1 PROG, bit2 SC, bit3 ALIGN, bit4 DSI, bit5 EXT, bits7:6 unused (0); bits 7:5 replaced by prog_cause for PROG with bit1 also set.
REQ-025 flush high exactly one cycle, in CAPTURE.
REQ-026 busy high in CAPTURE, DRAIN, SAVE, REDIRECT; low in IDLE.
REQ-027 srr_we and msr_ee_clr high exactly one cycle, in SAVE; dear_we high in SAVE only for ALIGN/DSI.
REQ-028 redirect_valid high exactly one cycle, in REDIRECT.
REQ-029 DRAIN has no timeout; pipe_idle already high gives one DRAIN cycle.
REQ-030 excep_code holds the latched cause from CAPTURE through REDIRECT, 0 in IDLE.
REQ-031 Minimum latency: request at cycle N -> flush N+1, SAVE N+3, redirect N+4, new request accepted N+5.

Reset
REQ-032 rst in any state forces IDLE on the next edge; all outputs 0, latched pc/addr/cause cleared.
REQ-033 rst mid-sequence suppresses any pending srr_we/dear_we/redirect_valid.

Structure
REQ-034 Package excep_pkg holds state enum, cause codes, esr bit positions and vector offsets.
REQ-035 Sub-module excep_prio_enc implements REQ-020/021 combinationally, returning winner code and one-hot grant.

Verification
REQ-036 req_sc, req_pc=0x100, pipe_idle=1 -> flush N+1, srr_we N+3 srr0=0x104 esr=0x04, redirect_pc=0xC00 at N+4.
REQ-037 req_isi+req_dsi same cycle -> ISI wins, redirect_pc=0x400, dear_we never high.
REQ-038 req_dsi, req_addr=0xDEAD_BEE0, pipe_idle low 5 cycles -> dear=0xDEAD_BEE0 one cycle after pipe_idle rises, redirect_pc=0x300.
REQ-039 ext_int=1 msr_ee=0 -> no flush; raise msr_ee -> EXT sequence, msr_ee_clr pulse, redirect_pc=0x500.
REQ-040 rst asserted in DRAIN -> IDLE next cycle, no srr_we/redirect_valid ever; req_sc, req_pc=0xFFFF_FFFC -> srr0=0x0000_0000.
